// File: rtl/branch_compare_pkg.sv
// -----------------------------------------------------------------------------
// branch_compare_pkg
// Shared definitions for the multi-cycle branch-condition evaluator:
//   - RV32 branch funct3 codes
//   - FSM state encoding
//   - helpers that decode signedness, legality and the taken flag
// -----------------------------------------------------------------------------
package branch_compare_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3[1] clear selects a signed compare. The illegal codes 010/011
    // have bit 1 set, so they fall through to an unsigned scan.
    function automatic logic is_signed_code(input logic [2:0] funct3);
        return !funct3[1];
    endfunction

    function automatic logic is_branch_code(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       less);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = !zero;
            F3_BLT, F3_BLTU:  taken = less;
            F3_BGE, F3_BGEU:  taken = !less;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_compare_chunk_compare.sv
// -----------------------------------------------------------------------------
// chunk_compare
// Combinational CHUNK-bit magnitude compare.
//   a_i, b_i      : operand chunks
//   signed_top_i  : chunk holds the operand sign bits; flip both MSBs so an
//                   unsigned compare yields the two's-complement ordering
//   eq_o          : a_i == b_i
//   lt_o          : a_i <  b_i (after the optional MSB flip)
// -----------------------------------------------------------------------------
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             signed_top_i,
    output logic             eq_o,
    output logic             lt_o
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = signed_top_i;
    end

    assign a_m  = a_i ^ flip;
    assign b_m  = b_i ^ flip;

    // Flipping the same bit on both sides cannot change equality.
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_m < b_m);

endmodule

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Multi-cycle RV32 branch-condition evaluator. Scans the operands MSB-first,
// CHUNK bits per cycle, and stops at the first differing chunk.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : request handshake (in_a, in_b, in_funct3)
//   flush                    : synchronous abort of any request in flight
//   out_valid/out_ready      : result handshake
//   out_taken/zero/less/err  : registered result, held until consumed
// -----------------------------------------------------------------------------
module branch_compare
    import branch_compare_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_zero,
    output logic            out_less,
    output logic            out_err
);

    localparam int N     = XLEN / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    if ((CHUNK < 1) || (CHUNK > XLEN) || (XLEN % CHUNK != 0)) begin : g_bad_chunk
        $error("branch_compare: CHUNK must divide XLEN");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  a_q, b_q;
    logic [2:0]       funct3_q;
    logic             taken_q, zero_q, less_q, err_q;
    logic             zero_d, less_d;
    logic             load;
    logic             res_upd;

    logic [CHUNK-1:0] a_chunks [N];
    logic [CHUNK-1:0] b_chunks [N];
    logic             signed_top;
    logic             chunk_eq;
    logic             chunk_lt;

    for (genvar g = 0; g < N; g++) begin : g_split
        assign a_chunks[g] = a_q[g*CHUNK +: CHUNK];
        assign b_chunks[g] = b_q[g*CHUNK +: CHUNK];
    end

    assign signed_top = is_signed_code(funct3_q) && (idx_q == IDX_TOP);

    chunk_compare #(
        .CHUNK        (CHUNK)
    ) u_chunk_compare (
        .a_i          (a_chunks[idx_q]),
        .b_i          (b_chunks[idx_q]),
        .signed_top_i (signed_top),
        .eq_o         (chunk_eq),
        .lt_o         (chunk_lt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        less_d  = less_q;
        load    = 1'b0;
        res_upd = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = IDX_TOP;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!chunk_eq) begin
                    zero_d  = 1'b0;
                    less_d  = chunk_lt;
                    res_upd = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    zero_d  = 1'b1;
                    less_d  = 1'b0;
                    res_upd = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over acceptance, scan progress and result capture.
        if (flush) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            res_upd = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            taken_q <= 1'b0;
            zero_q  <= 1'b0;
            less_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (res_upd) begin
                taken_q <= branch_taken(funct3_q, zero_d, less_d);
                zero_q  <= zero_d;
                less_q  <= less_d;
                err_q   <= !is_branch_code(funct3_q);
            end
        end
    end

    // NOTE: the operand latches carry no reset; they are only read in SCAN,
    // which is always entered through a load, so a reset would buy nothing.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q      <= in_a;
            b_q      <= in_b;
            funct3_q <= in_funct3;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_taken = taken_q;
    assign out_zero  = zero_q;
    assign out_less  = less_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_branch_compare.sv
// -----------------------------------------------------------------------------
// tb_branch_compare
// Directed-vector bench for branch_compare at XLEN=32, CHUNK=8. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_branch_compare;

    localparam int XLEN  = 32;
    localparam int CHUNK = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_funct3;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_zero;
    logic            out_less;
    logic            out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_compare #(
        .XLEN      (XLEN),
        .CHUNK     (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_funct3 (in_funct3),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_taken (out_taken),
        .out_zero  (out_zero),
        .out_less  (out_less),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for out_valid, counting edges after the accept edge. Called at the
    // falling edge right after the accept edge. Returns the edge count.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    // Full transaction: present, accept, wait, check, consume.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input int exp_j,
                          input logic exp_taken, input logic exp_zero,
                          input logic exp_less, input logic exp_err);
        int j;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(j);
        check({tag, ".lat"}, 32'(j), 32'(exp_j));
        check({tag, ".res"}, {28'd0, out_taken, out_zero, out_less, out_err},
              {28'd0, exp_taken, exp_zero, exp_less, exp_err});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int  j;
        bit  saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_funct3 = 3'b000;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.outs", {27'd0, out_valid, out_taken, out_zero, out_less, out_err}, 32'd0);
        check("reset.ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        //     tag         a             b             f3      j  tk zr ls er
        run_op("beq_eq",   32'h12345678, 32'h12345678, 3'b000, 4, 1, 1, 0, 0);
        run_op("bltu_top", 32'h80000000, 32'h00000001, 3'b110, 1, 0, 0, 0, 0);
        run_op("blt_top",  32'h80000000, 32'h00000001, 3'b100, 1, 1, 0, 1, 0);
        run_op("bge_c1",   32'h00000100, 32'h000000FF, 3'b101, 3, 1, 0, 0, 0);
        run_op("illegal",  32'h00000005, 32'h00000005, 3'b010, 4, 0, 1, 0, 1);
        run_op("illeg011", 32'h00000001, 32'h00000002, 3'b011, 4, 0, 0, 1, 1);
        run_op("bne_c0",   32'h00000001, 32'h00000002, 3'b001, 4, 1, 0, 1, 0);
        run_op("bgeu_top", 32'hFFFFFFFF, 32'h00000000, 3'b111, 1, 1, 0, 0, 0);
        run_op("blt_neg",  32'hFFFFFFFF, 32'h00000000, 3'b100, 1, 1, 0, 1, 0);
        run_op("bge_neg",  32'h7FFFFFFF, 32'h80000000, 3'b101, 1, 1, 0, 0, 0);

        // Backpressure: first request BEQ 0xA/0xB, second request kept pending.
        in_valid  = 1'b1;
        in_a      = 32'h0000000A;
        in_b      = 32'h0000000B;
        in_funct3 = 3'b000;
        @(posedge clk);
        @(negedge clk);
        in_a      = 32'hFFFFFFFF;
        in_b      = 32'h00000001;
        in_funct3 = 3'b100;
        wait_done(j);
        check("bp.lat", 32'(j), 32'd4);
        for (int k = 0; k < 5; k++) begin
            check("bp.hold", {26'd0, in_ready, out_valid, out_taken, out_zero, out_less, out_err},
                  32'b01_0010);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.idle", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.accept", 32'(in_ready), 32'd0);
        wait_done(j);
        check("bp2.lat", 32'(j), 32'd1);
        check("bp2.res", {28'd0, out_taken, out_zero, out_less, out_err}, 32'b1010);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Flush at E2 of an equal-operand BEQ.
        in_valid  = 1'b1;
        in_a      = 32'h55555555;
        in_b      = 32'h55555555;
        in_funct3 = 3'b000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush.idle", {30'd0, in_ready, out_valid}, 32'b10);
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush.noval", 32'(saw_valid), 32'd0);

        // Leave non-zero results behind, then reset mid-scan.
        run_op("beq_pre",  32'h00000000, 32'h00000000, 3'b000, 4, 1, 1, 0, 0);
        in_valid  = 1'b1;
        in_a      = 32'hCAFEF00D;
        in_b      = 32'hCAFEF00D;
        in_funct3 = 3'b000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst.async", {27'd0, out_valid, out_taken, out_zero, out_less, out_err}, 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst.ready", {30'd0, in_ready, out_valid}, 32'b10);
        run_op("post_rst", 32'h00000010, 32'h00000020, 3'b110, 4, 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_compare.md
# branch_compare

Parametrised, multi-cycle branch-condition evaluator for the RISC-V pipeline. It compares two XLEN-bit operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk. It resolves all six RV32 branch conditions (signed and unsigned) and returns taken/zero/less through a valid/ready handshake. It replaces the single-cycle equal/less-than comparator wherever the full-width compare does not meet timing.

## Interface
- XLEN, 32, operand width
- CHUNK, 8, bits compared per cycle; must divide XLEN, 1 ≤ CHUNK ≤ XLEN
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_a  in  XLEN  operand rs1
- in_b  in  XLEN  operand rs2
- in_funct3  in  3  branch condition code
- flush  in  1  synchronous abort of any request in flight
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  branch condition true
- out_zero  out  1  in_a == in_b
- out_less  out  1  in_a < in_b, signed or unsigned per funct3
- out_err  out  1  funct3 is not a branch code

## Operation
- Condition codes: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. funct3[1]=0 means a signed compare.
- Codes 010 and 011 are illegal: the scan runs unsigned, then out_err=1 and out_taken=0.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. When in_valid is high, latch a, b and funct3, set idx=N-1 (N=XLEN/CHUNK), and go to SCAN.
- SCAN: in_ready=0. Compare chunk idx of a against chunk idx of b.
  - For signed codes, invert the MSB of both operands in the top chunk (idx=N-1) before comparing.
  - Chunks differ: zero=0, less=(a_chunk<b_chunk), go to DONE.
  - Chunks equal and idx=0: zero=1, less=0, go to DONE.
  - Otherwise decrement idx.
- DONE: out_valid=1. Results are held stable until out_valid && out_ready, then return to IDLE. No new request is accepted in the same cycle the result is consumed.
- out_taken by code: BEQ=zero, BNE=!zero, BLT/BLTU=less, BGE/BGEU=!less.
- flush: in any state, the next edge goes to IDLE with out_valid=0. flush overrides acceptance and scan progress.
- rst: asserting it mid-operation immediately returns to IDLE and clears all outputs.

## Timing
- Reset values: out_valid=0, out_taken=0, out_zero=0, out_less=0, out_err=0, state=IDLE (so in_ready=1).
- in_ready and out_valid are decoded from state. Result outputs are registered. There is no combinational path from in_* to out_*.
- Latency: call the accept edge E0. out_valid rises after edge Ej, where j = number of chunks scanned (1..N).
  - Top chunk differs: out_valid after E1.
  - Equal operands: out_valid after EN.
- Throughput: at most one request per j+2 cycles.
- CHUNK=XLEN gives fixed 1-cycle-scan latency.
- Result outputs are don't-care while out_valid=0, but only change on a DONE entry or on reset.

## Structure
- Shared package holds:
  - funct3 branch-code localparams (BEQ…BGEU)
  - FSM state encoding
  - a function to decode taken from (funct3, zero, less)
- Sub-module chunk_compare: combinational CHUNK-bit compare producing eq and lt, with a signed_top input that applies the MSB inversion. Instantiated once and muxed by idx.
- Elaboration-time check: abort if XLEN % CHUNK != 0.

## Test plan
XLEN=32, CHUNK=8 throughout.
- BEQ, a=b=0x12345678 → out_valid after E4; taken=1, zero=1, less=0.
- BLTU, a=0x80000000, b=0x00000001 → after E1: taken=0, less=0. Same operands with BLT → after E1: taken=1, less=1.
- BGE, a=0x00000100, b=0x000000FF → decided on chunk 1, out_valid after E3; taken=1, zero=0, less=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → outputs stable, in_ready=0, no new request latched. Raise out_ready → IDLE next edge, then the pending request is accepted.
- Illegal code: funct3=010, any operands → out_err=1, taken=0 on completion.
- Flush and reset mid-SCAN:
  - flush at E2 of a BEQ on equal operands → IDLE after that edge, out_valid never asserts.
  - async rst pulse mid-SCAN → all outputs 0 immediately, in_ready=1 once rst drops.
